// File: rtl/prio_hist_disp.sv
// prio_hist_disp
// Display back end for an 8-to-3 switch priority encoder. The {valid,code}
// pair is synchronized and debounced. Each settled change is pushed into a
// six-deep history, and an 8-bit change counter is stepped. The history and
// the counter are time-multiplexed onto an eight-digit active-low
// seven-segment bank.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   code  : encoder index of the highest switch that is on
//   valid : encoder flag, 1 = at least one switch is on
//   seg   : active-low segments {dp,g,f,e,d,c,b,a}; dp is always off (1)
//   an    : active-low digit enables, bit i selects digit i
//
// Digit map
//   0..5 : history entries, newest at digit 0
//          (blank if empty, dash if no switch was on, otherwise hex code)
//   6    : counter low nibble
//   7    : counter high nibble
module prio_hist_disp #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SCAN_DIV      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       valid,
  output logic [7:0] seg,
  output logic [7:0] an
);

  localparam logic [7:0]  STAB_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0]  STAB_MATURE = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] DIV_LAST    = 16'(SCAN_DIV - 1);

  // Two-stage synchronizer on {valid,code}.
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] s;
  logic       s_match;

  logic [7:0] stab_q, stab_d;
  logic [3:0] last_q;
  logic [4:0] hist_q [0:5];   // {filled, valid, code}
  logic [7:0] cnt_q;
  logic       commit;

  logic [15:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  pat;

  assign s = sync2_q;
  // The stability check compares the two synchronizer stages. This is the
  // same as comparing the sample with its one-cycle-delayed copy, but one
  // stage earlier. A change held from edge N therefore commits on edge
  // N+1+STABLE_CYCLES.
  assign s_match = (sync1_q == sync2_q);

  always_comb begin
    stab_d = stab_q;
    if (!s_match)
      stab_d = 8'd0;
    else if (stab_q < STAB_MAX)
      stab_d = stab_q + 8'd1;
  end

  // Only equality with the last committed value blocks a commit. A toggle
  // between two values therefore commits every settled change.
  assign commit = (stab_q == STAB_MATURE) && s_match && (s != last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stab_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < 6; k++) hist_q[k] <= '0;
    end else begin
      sync1_q <= {valid, code};
      sync2_q <= sync1_q;
      stab_q  <= stab_d;
      if (commit) begin
        last_q <= s;
        cnt_q  <= cnt_q + 8'd1;
        for (int k = 5; k > 0; k--) hist_q[k] <= hist_q[k-1];
        hist_q[0] <= {1'b1, s};
      end
    end
  end

  // Scan counters: div runs 0..SCAN_DIV-1; idx steps on the div wrap.
  always_comb begin
    div_d = div_q + 16'd1;
    idx_d = idx_q;
    if (div_q >= DIV_LAST) begin
      div_d = 16'd0;
      idx_d = idx_q + 3'd1;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  function automatic logic [6:0] hist_pat(input logic [4:0] e);
    logic [6:0] p;
    if (!e[4])
      p = 7'h7F;                   // empty slot: blank
    else if (!e[3])
      p = 7'h3F;                   // no switch on: dash
    else
      p = hex7({1'b0, e[2:0]});
    return p;
  endfunction

  // Digit content from the current (pre-commit) state. A commit landing on
  // the digit being scanned shows up one cycle later.
  always_comb begin
    pat = 7'h7F;
    case (idx_q)
      3'd0: pat = hist_pat(hist_q[0]);
      3'd1: pat = hist_pat(hist_q[1]);
      3'd2: pat = hist_pat(hist_q[2]);
      3'd3: pat = hist_pat(hist_q[3]);
      3'd4: pat = hist_pat(hist_q[4]);
      3'd5: pat = hist_pat(hist_q[5]);
      3'd6: pat = hex7(cnt_q[3:0]);
      default: pat = hex7(cnt_q[7:4]);
    endcase
    seg_d = {1'b1, pat};
    an_d  = ~(8'b1 << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      seg_q <= 8'hFF;
      an_q  <= 8'hFF;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_prio_hist_disp.sv
// Directed bench for prio_hist_disp with default parameters
// (STABLE_CYCLES=4, SCAN_DIV=8).
module tb_prio_hist_disp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code = 3'd0;
  logic       valid = 1'b0;
  logic [7:0] seg, an;

  int total = 0;
  int bad   = 0;

  prio_hist_disp dut (
    .clk   (clk),
    .rst   (rst),
    .code  (code),
    .valid (valid),
    .seg   (seg),
    .an    (an)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Apply {valid,code} at a falling edge and hold it for n cycles.
  task automatic apply(input logic v, input logic [2:0] c, input int n);
    valid = v;
    code  = c;
    wait_neg(n);
  endtask

  // Wait (bounded) for digit d to be selected and return its segments.
  task automatic read_digit(input int d, output logic [7:0] s, output bit found);
    logic [7:0] target;
    target = ~(8'b1 << d);
    found = 1'b0;
    s = 8'hxx;
    for (int k = 0; k < 80 && !found; k++) begin
      if (an === target) begin
        s = seg;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] s;
    bit f;
    rst = 1'b1;
    wait_neg(3);
    total++;
    if (seg !== 8'hFF) begin bad++; $display("FAIL rst_seg got=%h exp=FF", seg); end
    total++;
    if (an !== 8'hFF) begin bad++; $display("FAIL rst_an got=%h exp=FF", an); end
    rst = 1'b0;
    @(negedge clk);  // after edge 0
    total++;
    if (an !== 8'hFE) begin bad++; $display("FAIL edge0_an got=%h exp=FE", an); end
    total++;
    if (seg !== 8'hFF) begin bad++; $display("FAIL edge0_seg got=%h exp=FF", seg); end
    read_digit(6, s, f);
    total++;
    if (!f || s !== 8'hC0) begin bad++; $display("FAIL rst_dig6 got=%h found=%0d exp=C0", s, f); end
    read_digit(7, s, f);
    total++;
    if (!f || s !== 8'hC0) begin bad++; $display("FAIL rst_dig7 got=%h found=%0d exp=C0", s, f); end
  endtask

  task automatic test_single_commit();
    logic [7:0] s;
    bit f;
    valid = 1'b1;
    code  = 3'd5;   // changes before edge N
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);  // after edge N+k
      if (k == 4) begin
        total++;
        if (dut.cnt_q !== 8'd0) begin bad++; $display("FAIL early_commit cnt=%0d exp=0", dut.cnt_q); end
      end
      if (k == 5) begin
        total++;
        if (dut.cnt_q !== 8'd1) begin bad++; $display("FAIL commit_edge cnt=%0d exp=1", dut.cnt_q); end
      end
    end
    wait_neg(4);
    read_digit(0, s, f);
    total++;
    if (!f || s !== 8'h92) begin bad++; $display("FAIL single_dig0 got=%h found=%0d exp=92", s, f); end
    read_digit(6, s, f);
    total++;
    if (!f || s !== 8'hF9) begin bad++; $display("FAIL single_dig6 got=%h found=%0d exp=F9", s, f); end
  endtask

  task automatic test_glitch();
    logic [7:0] s;
    bit f;
    apply(1'b1, 3'd3, 3);
    apply(1'b1, 3'd5, 20);
    total++;
    if (dut.cnt_q !== 8'd1) begin bad++; $display("FAIL glitch_cnt got=%0d exp=1", dut.cnt_q); end
    read_digit(0, s, f);
    total++;
    if (!f || s !== 8'h92) begin bad++; $display("FAIL glitch_dig0 got=%h found=%0d exp=92", s, f); end
  endtask

  task automatic test_depth();
    logic [7:0] s;
    logic [7:0] exp_d [0:7];
    bit f;
    // fresh start so the counter reads 07 after seven commits
    rst = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    for (int c = 1; c <= 7; c++) apply(1'b1, 3'(c), 10);
    exp_d[0] = 8'hF8;  // 7
    exp_d[1] = 8'h82;  // 6
    exp_d[2] = 8'h92;  // 5
    exp_d[3] = 8'h99;  // 4
    exp_d[4] = 8'hB0;  // 3
    exp_d[5] = 8'hA4;  // 2
    exp_d[6] = 8'hF8;  // cnt low 7
    exp_d[7] = 8'hC0;  // cnt high 0
    for (int d = 0; d < 8; d++) begin
      read_digit(d, s, f);
      total++;
      if (!f || s !== exp_d[d]) begin
        bad++;
        $display("FAIL depth_dig%0d got=%h found=%0d exp=%h", d, s, f, exp_d[d]);
      end
    end
  endtask

  task automatic test_no_switch();
    logic [7:0] s;
    bit f;
    apply(1'b0, 3'd0, 10);
    read_digit(0, s, f);
    total++;
    if (!f || s !== 8'hBF) begin bad++; $display("FAIL dash_dig0 got=%h found=%0d exp=BF", s, f); end
    read_digit(1, s, f);
    total++;
    if (!f || s !== 8'hF8) begin bad++; $display("FAIL dash_dig1 got=%h found=%0d exp=F8", s, f); end
    // re-apply the same no-switch value: no second commit
    apply(1'b1, 3'd0, 2);
    apply(1'b0, 3'd0, 20);
    total++;
    if (dut.cnt_q !== 8'd8) begin bad++; $display("FAIL dash_repeat cnt=%0d exp=8", dut.cnt_q); end
    read_digit(6, s, f);
    total++;
    if (!f || s !== 8'h80) begin bad++; $display("FAIL dash_dig6 got=%h found=%0d exp=80", s, f); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    bit f;
    // cnt = 8 here; 248 more commits wrap it to 00
    for (int i = 0; i < 248; i++) apply(1'b1, (i % 2 == 1) ? 3'd2 : 3'd1, 6);
    wait_neg(4);
    read_digit(6, s, f);
    total++;
    if (!f || s !== 8'hC0) begin bad++; $display("FAIL wrap_dig6 got=%h found=%0d exp=C0", s, f); end
    read_digit(7, s, f);
    total++;
    if (!f || s !== 8'hC0) begin bad++; $display("FAIL wrap_dig7 got=%h found=%0d exp=C0", s, f); end
    read_digit(0, s, f);
    total++;
    if (!f || s !== 8'hA4) begin bad++; $display("FAIL wrap_dig0 got=%h found=%0d exp=A4", s, f); end
    read_digit(1, s, f);
    total++;
    if (!f || s !== 8'hF9) begin bad++; $display("FAIL wrap_dig1 got=%h found=%0d exp=F9", s, f); end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] s;
    bit f;
    read_digit(3, s, f);
    total++;
    if (!f) begin bad++; $display("FAIL mid_reach_dig3 got=timeout exp=selected"); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (seg !== 8'hFF) begin bad++; $display("FAIL mid_rst_seg got=%h exp=FF", seg); end
    total++;
    if (an !== 8'hFF) begin bad++; $display("FAIL mid_rst_an got=%h exp=FF", an); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 8'hFE) begin bad++; $display("FAIL post_rst_an got=%h exp=FE", an); end
    total++;
    if (seg !== 8'hFF) begin bad++; $display("FAIL post_rst_seg got=%h exp=FF", seg); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_commit();
    test_glitch();
    test_depth();
    test_no_switch();
    test_back_to_back();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
